// File: rtl/hazard_sequencer.sv
// hazard_sequencer: front-end stall/flush/redirect control with mult/div occupancy and stall-cycle counter
module hazard_sequencer #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 jump,
  input  logic                 branch_flag,
  input  logic                 reg_equal_flag,
  input  logic [4:0]           id_rs,
  input  logic [4:0]           id_rt,
  input  logic                 id_uses_rt,
  input  logic                 ex_mem_read,
  input  logic [4:0]           ex_rt,
  input  logic                 md_start,
  input  logic                 id_md_dep,
  input  logic                 imem_ready,
  output logic                 pc_write,
  output logic                 if_id_stall,
  output logic                 if_id_flush,
  output logic                 id_ex_bubble,
  output logic                 redirect_take,
  output logic                 md_busy,
  output logic [CNT_WIDTH-1:0] stall_cycles
);
  typedef enum logic {IDLE, BUSY} md_state_t;
  md_state_t state, state_n;
  logic [7:0] md_cnt, md_cnt_n;
  logic redirect, load_use, md_hold, stall, md_accept;
  assign redirect = jump || (branch_flag && reg_equal_flag);
  assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                    (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
  assign md_busy = state == BUSY;
  assign md_hold = md_busy && (md_start || id_md_dep);
  assign stall = !reset && (load_use || md_hold);
  assign pc_write = !reset && !stall && (redirect || imem_ready);
  assign if_id_stall = stall;
  assign id_ex_bubble = stall;
  assign redirect_take = !reset && !stall && redirect;
  assign if_id_flush = !reset && !stall && (redirect || !imem_ready);
  assign md_accept = md_start && !stall;
  always_comb begin
    state_n = (state == IDLE) ? (md_accept ? BUSY : IDLE) : (md_cnt == 8'd0 ? IDLE : BUSY);
    md_cnt_n = (state == IDLE) ? (md_accept ? 8'(MD_LATENCY - 1) : md_cnt)
                               : (md_cnt == 8'd0 ? md_cnt : md_cnt - 8'd1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      md_cnt <= 8'd0;
      stall_cycles <= '0;
    end else begin
      state <= state_n;
      md_cnt <= md_cnt_n;
      if (!pc_write && stall_cycles != {CNT_WIDTH{1'b1}})
        stall_cycles <= stall_cycles + CNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_hazard_sequencer.sv
// tb_hazard_sequencer: directed checks of hazard_sequencer decisions, mult/div occupancy and stall counter
module tb_hazard_sequencer;
  localparam int CW = 4;
  localparam logic [4:0] RUN = 5'b10000, STALL = 5'b01010, REDIR = 5'b10101, WAIT = 5'b00100, ZERO = 5'b00000;
  logic clk = 1'b0, reset = 1'b0;
  logic jump, branch_flag, reg_equal_flag, id_uses_rt, ex_mem_read, md_start, id_md_dep, imem_ready;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic pc_write, if_id_stall, if_id_flush, id_ex_bubble, redirect_take, md_busy;
  logic [CW-1:0] stall_cycles;
  logic [4:0] ctl;
  int checks = 0, errors = 0;

  hazard_sequencer #(.MD_LATENCY(4), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .jump(jump), .branch_flag(branch_flag), .reg_equal_flag(reg_equal_flag),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .md_start(md_start), .id_md_dep(id_md_dep), .imem_ready(imem_ready), .pc_write(pc_write),
    .if_id_stall(if_id_stall), .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .redirect_take(redirect_take), .md_busy(md_busy), .stall_cycles(stall_cycles));

  assign ctl = {pc_write, if_id_stall, if_id_flush, id_ex_bubble, redirect_take};
  always #5 clk = ~clk;

  task automatic idle_inputs();
    jump = 0; branch_flag = 0; reg_equal_flag = 0; id_uses_rt = 0; ex_mem_read = 0;
    md_start = 0; id_md_dep = 0; imem_ready = 1; id_rs = 0; id_rt = 0; ex_rt = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    #1;
    checks++;
    if (ctl !== ZERO) begin errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl, ZERO); end
    tick();
    reset = 0;
    #1;
    checks++;
    if (stall_cycles !== 0 || md_busy !== 0) begin errors++; $display("FAIL reset_state cnt=%0d busy=%b exp 0/0", stall_cycles, md_busy); end
    checks++;
    if (ctl !== RUN) begin errors++; $display("FAIL reset_run got=%b exp=%b", ctl, RUN); end
  endtask

  task automatic test_load_use();
    do_reset();
    ex_mem_read = 1; ex_rt = 8; id_rs = 8;
    #1;
    checks++;
    if (ctl !== STALL) begin errors++; $display("FAIL load_use_rs got=%b exp=%b", ctl, STALL); end
    tick();
    ex_mem_read = 0;
    #1;
    checks++;
    if (ctl !== RUN || stall_cycles !== 1) begin errors++; $display("FAIL load_use_after ctl=%b cnt=%0d exp %b/1", ctl, stall_cycles, RUN); end
    ex_mem_read = 1; ex_rt = 0; id_rs = 0;
    #1;
    checks++;
    if (ctl !== RUN) begin errors++; $display("FAIL load_use_r0 got=%b exp=%b", ctl, RUN); end
    ex_rt = 9; id_rs = 3; id_rt = 9; id_uses_rt = 1;
    #1;
    checks++;
    if (ctl !== STALL) begin errors++; $display("FAIL load_use_rt got=%b exp=%b", ctl, STALL); end
    id_uses_rt = 0;
    #1;
    checks++;
    if (ctl !== RUN) begin errors++; $display("FAIL load_use_rt_unused got=%b exp=%b", ctl, RUN); end
  endtask

  task automatic test_branch();
    do_reset();
    branch_flag = 1; reg_equal_flag = 1;
    #1;
    checks++;
    if (ctl !== REDIR) begin errors++; $display("FAIL branch_taken got=%b exp=%b", ctl, REDIR); end
    reg_equal_flag = 0;
    #1;
    checks++;
    if (ctl !== RUN) begin errors++; $display("FAIL branch_not_taken got=%b exp=%b", ctl, RUN); end
    branch_flag = 0; jump = 1; imem_ready = 0;
    #1;
    checks++;
    if (ctl !== REDIR) begin errors++; $display("FAIL jump_imem_wait got=%b exp=%b", ctl, REDIR); end
    tick();
    checks++;
    if (stall_cycles !== 0) begin errors++; $display("FAIL redirect_no_count got=%0d exp=0", stall_cycles); end
  endtask

  task automatic test_priority();
    do_reset();
    ex_mem_read = 1; ex_rt = 5; id_rs = 5; jump = 1;
    #1;
    checks++;
    if (ctl !== STALL) begin errors++; $display("FAIL prio_stall got=%b exp=%b", ctl, STALL); end
    tick();
    ex_mem_read = 0;
    #1;
    checks++;
    if (ctl !== REDIR) begin errors++; $display("FAIL prio_redirect_next got=%b exp=%b", ctl, REDIR); end
  endtask

  task automatic test_muldiv();
    do_reset();
    md_start = 1;
    #1;
    checks++;
    if (ctl !== RUN || md_busy !== 0) begin errors++; $display("FAIL md_accept ctl=%b busy=%b exp %b/0", ctl, md_busy, RUN); end
    tick();
    md_start = 0; id_md_dep = 1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      checks++;
      if (ctl !== STALL || md_busy !== 1) begin errors++; $display("FAIL md_dep_hold t+%0d ctl=%b busy=%b exp %b/1", i, ctl, md_busy, STALL); end
      tick();
    end
    id_md_dep = 0; md_start = 1;
    #1;
    checks++;
    if (ctl !== RUN || md_busy !== 0 || stall_cycles !== 4) begin errors++; $display("FAIL md_free ctl=%b busy=%b cnt=%0d exp %b/0/4", ctl, md_busy, stall_cycles, RUN); end
    tick();
    for (int i = 1; i <= 4; i++) begin
      #1;
      checks++;
      if (ctl !== STALL || md_busy !== 1) begin errors++; $display("FAIL md_b2b_hold t+%0d ctl=%b busy=%b exp %b/1", i, ctl, md_busy, STALL); end
      tick();
    end
    #1;
    checks++;
    if (ctl !== RUN || md_busy !== 0 || stall_cycles !== 8) begin errors++; $display("FAIL md_b2b_accept ctl=%b busy=%b cnt=%0d exp %b/0/8", ctl, md_busy, stall_cycles, RUN); end
    tick();
    md_start = 0;
    #1;
    checks++;
    if (md_busy !== 1) begin errors++; $display("FAIL md_b2b_busy got=%b exp=1", md_busy); end
  endtask

  task automatic test_reset_mid_busy();
    reset = 1;
    #1;
    checks++;
    if (ctl !== ZERO) begin errors++; $display("FAIL reset_mid_ctl got=%b exp=%b", ctl, ZERO); end
    tick();
    reset = 0;
    #1;
    checks++;
    if (md_busy !== 0 || stall_cycles !== 0) begin errors++; $display("FAIL reset_mid_busy busy=%b cnt=%0d exp 0/0", md_busy, stall_cycles); end
  endtask

  task automatic test_imem_wait();
    do_reset();
    imem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctl !== WAIT) begin errors++; $display("FAIL imem_wait cyc%0d got=%b exp=%b", i, ctl, WAIT); end
      tick();
    end
    imem_ready = 1;
    #1;
    checks++;
    if (ctl !== RUN || stall_cycles !== 3) begin errors++; $display("FAIL imem_resume ctl=%b cnt=%0d exp %b/3", ctl, stall_cycles, RUN); end
  endtask

  task automatic test_saturation();
    do_reset();
    imem_ready = 0;
    for (int i = 0; i < 14; i++) tick();
    checks++;
    if (stall_cycles !== 14) begin errors++; $display("FAIL sat_pre got=%0d exp=14", stall_cycles); end
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (stall_cycles !== 15) begin errors++; $display("FAIL sat_hold got=%0d exp=15", stall_cycles); end
    imem_ready = 1;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_load_use();
    test_branch();
    test_priority();
    test_muldiv();
    test_reset_mid_busy();
    test_imem_wait();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_sequencer.md
# hazard_sequencer

Front-end pipeline controller. It generates the PC write enable and the IF/ID stall/flush controls, plus the ID/EX bubble and redirect select, for the 5-stage core. It resolves load-use hazards, multi-cycle multiply/divide occupancy, branch/jump redirects and instruction-memory wait states into one consistent per-cycle decision. It also keeps a saturating count of fetch-stall cycles for performance monitoring.

## Interface
- MD_LATENCY, 4, cycles the multiply/divide unit stays busy after accepting an op (range 1..255)
- CNT_WIDTH, 16, width of the stall-cycle counter

- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- jump  in  1  jump decoded in ID
- branch_flag  in  1  branch decoded in ID
- reg_equal_flag  in  1  ID register comparison equal
- id_rs  in  5  rs field of ID instruction
- id_rt  in  5  rt field of ID instruction
- id_uses_rt  in  1  ID instruction reads rt as a source
- ex_mem_read  in  1  instruction in EX is a load
- ex_rt  in  5  load destination register in EX
- md_start  in  1  ID instruction is a mult/div op
- id_md_dep  in  1  ID instruction reads HI/LO
- imem_ready  in  1  instruction memory word valid this cycle
- pc_write  out  1  PC register load enable
- if_id_stall  out  1  hold IF/ID
- if_id_flush  out  1  load bubble (zeros) into IF/ID
- id_ex_bubble  out  1  zero control fields into ID/EX
- redirect_take  out  1  PC mux selects branch/jump target
- md_busy  out  1  multiply/divide unit occupied
- stall_cycles  out  CNT_WIDTH  saturating count of cycles with pc_write=0

## Operation
- Definitions:
  - redirect = jump | (branch_flag & reg_equal_flag)
  - load_use = ex_mem_read & (ex_rt != 0) & (ex_rt == id_rs | (id_uses_rt & ex_rt == id_rt))
  - md_hold = md_busy & (md_start | id_md_dep)
- Per-cycle decision, evaluated in strict priority order (combinational from inputs and state):
  1. reset: all control outputs 0.
  2. load_use | md_hold → STALL: pc_write=0, if_id_stall=1, id_ex_bubble=1, redirect_take=0, if_id_flush=0. A redirect in the same cycle is suppressed and re-evaluated next cycle.
  3. redirect → REDIRECT: pc_write=1, redirect_take=1, if_id_flush=1. This overrides imem_ready=0; the memory restarts at the target.
  4. !imem_ready → WAIT: pc_write=0, if_id_flush=1. The ID instruction still advances.
  5. Otherwise RUN: pc_write=1, all other controls 0.
- if_id_stall and if_id_flush are never both 1.
- Multiply/divide FSM, states IDLE and BUSY, with an 8-bit down-counter md_cnt:
  - IDLE → BUSY when md_start and the decision is not STALL. md_cnt loads MD_LATENCY-1.
  - In BUSY, md_cnt decrements each cycle. At md_cnt==0 the FSM returns to IDLE.
  - md_busy = (state==BUSY).
  - md_start arriving while BUSY is held by md_hold until the unit frees. It is accepted in the first cycle md_busy=0.
- stall_cycles increments on every non-reset cycle with pc_write=0, i.e. STALL or WAIT. It holds at 2^CNT_WIDTH-1.

## Timing
- Reset values: state IDLE, md_cnt 0, md_busy 0, stall_cycles 0. During reset: pc_write 0, if_id_stall 0, if_id_flush 0, id_ex_bubble 0, redirect_take 0.
- Control outputs have zero latency: they are combinational and valid in the same cycle as the inputs.
- md_busy rises the cycle after acceptance and stays high exactly MD_LATENCY cycles.
- Load-use stall lasts exactly 1 cycle, because the load moves to MEM.
- Reset asserted mid-BUSY aborts to IDLE on the next edge.
- stall_cycles updates on the edge ending the counted cycle.

## Test plan
- Load-use: ex_mem_read=1, ex_rt=8, id_rs=8 → 1 cycle of pc_write=0, if_id_stall=1, id_ex_bubble=1; then RUN; stall_cycles=1. Repeat with ex_rt=0 → no stall.
- Branch taken: branch_flag=1, reg_equal_flag=1 → redirect_take=1, if_id_flush=1, pc_write=1. Same with reg_equal_flag=0 → RUN. jump=1 together with imem_ready=0 → REDIRECT.
- Priority: load_use and jump asserted together → STALL with redirect_take=0. Next cycle, load_use clear and jump still 1 → REDIRECT.
- Mult/div with MD_LATENCY=4: md_start accepted at cycle t → md_busy=1 for t+1..t+4. A HI/LO reader (id_md_dep=1) held at t+1 stalls through t+4 and is accepted at t+5; stall_cycles=4. A back-to-back md_start is handled the same way.
- Imem wait: imem_ready=0 for 3 cycles → pc_write=0, if_id_flush=1 each cycle, if_id_stall=0; stall_cycles=3.
- Saturation and reset: with CNT_WIDTH=4, 20 stall cycles → stall_cycles=15. Reset asserted mid-BUSY → md_busy=0 and stall_cycles=0 after the edge.
